// File: rtl/vram_pkg.sv
// vram_pkg
// Shared definitions for the frame-buffer access scheduler.
//   ADDR_W / DATA_W : linear pixel address width and 4:4:4 pixel width
//   H_RES / V_RES   : visible raster size, PIX_COUNT = H_RES * V_RES
//   clr_state_t     : clear engine state encoding
//   grant_t         : which requester owns the RAM slot in a given cycle
package vram_pkg;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int PIX_COUNT = H_RES * V_RES;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 12;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_FIFO = 2'd2,
        GNT_CLR  = 2'd3
    } grant_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo
// Small synchronous FIFO buffering host pixel writes as {addr, data} entries.
// Ports:
//   pclk, reset      : pixel clock, asynchronous active-low reset (empties FIFO)
//   push, push_data  : enqueue an entry (ignored when full)
//   pop, pop_data    : dequeue the head entry (ignored when empty); pop_data
//                      always shows the current head
//   full, empty      : occupancy flags
module vram_wr_fifo #(
    parameter int ENTRY_W = 31,
    parameter int DEPTH   = 4
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] pop_data,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] storage [DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // when the index bits coincide.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = storage[rd_ptr[PTR_W-1:0]];

    // Pointer update; reset discards every pending entry.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage needs no reset: the pointers define what is valid.
    always_ff @(posedge pclk) begin
        if (do_push) storage[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter
// Single-port frame-buffer scheduler. One RAM slot per cycle, fixed priority:
// display read > buffered host write > clear-engine write.
// Ports:
//   pclk, reset                      : pixel clock, async active-low reset
//   disp_req, disp_addr              : scan-out read request (never stalled)
//   disp_data, disp_data_valid       : returned pixel, 3 cycles after request
//   wr_valid, wr_ready, wr_addr/data : host write handshake into the FIFO
//   clr_start, clr_color, clr_busy   : full-screen clear command and status
//   mem_addr, mem_we, mem_wdata      : registered RAM controls
//   mem_rdata                        : RAM read data, one cycle after address
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = vram_pkg::ADDR_W,
    parameter int DATA_W     = vram_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int PIX_COUNT  = vram_pkg::PIX_COUNT
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_data_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(PIX_COUNT - 1);

    clr_state_t        state_q;
    clr_state_t        state_d;
    grant_t            grant;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] clr_color_q;
    logic              clr_last;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [ADDR_W-1:0] fifo_addr;
    logic [DATA_W-1:0] fifo_data;
    logic [1:0]        disp_dly;

    // Host writes are refused for the whole clear so nothing can land on
    // top of the fill after it starts.
    assign wr_ready  = !fifo_full && (state_q == ST_IDLE);
    assign fifo_push = wr_valid && wr_ready;
    assign fifo_pop  = (grant == GNT_FIFO);
    assign clr_busy  = (state_q == ST_CLEAR);
    assign clr_last  = (clr_cnt == CLR_LAST);

    vram_wr_fifo #(
        .ENTRY_W (ADDR_W + DATA_W),
        .DEPTH   (FIFO_DEPTH)
    ) u_wr_fifo (
        .pclk      (pclk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({wr_addr, wr_data}),
        .pop       (fifo_pop),
        .pop_data  ({fifo_addr, fifo_data}),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Clear FSM state register.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Slot arbitration and clear FSM next state. Queued host writes beat the
    // clear, which is what makes writes accepted before clr_start land first.
    always_comb begin
        grant   = GNT_NONE;
        state_d = state_q;
        if (disp_req)               grant = GNT_DISP;
        else if (!fifo_empty)       grant = GNT_FIFO;
        else if (state_q == ST_CLEAR) grant = GNT_CLR;

        case (state_q)
            ST_IDLE:  if (clr_start) state_d = ST_CLEAR;
            ST_CLEAR: if (grant == GNT_CLR && clr_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Clear address counter and latched fill colour. The counter parks on
    // the last address rather than wrapping.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            clr_cnt     <= '0;
            clr_color_q <= '0;
        end else if (state_q == ST_IDLE && clr_start) begin
            clr_cnt     <= '0;
            clr_color_q <= clr_color;
        end else if (grant == GNT_CLR && !clr_last) begin
            clr_cnt     <= clr_cnt + 1'b1;
        end
    end

    // Registered RAM controls. Idle and display-read cycles keep the last
    // write data so the bus only toggles when a write is issued.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (grant)
                GNT_DISP: begin
                    mem_addr <= disp_addr;
                    mem_we   <= 1'b0;
                end
                GNT_FIFO: begin
                    mem_addr  <= fifo_addr;
                    mem_wdata <= fifo_data;
                    mem_we    <= 1'b1;
                end
                GNT_CLR: begin
                    mem_addr  <= clr_cnt;
                    mem_wdata <= clr_color_q;
                    mem_we    <= 1'b1;
                end
                default: mem_we <= 1'b0;
            endcase
        end
    end

    // Read return pipeline: request -> address register -> RAM -> capture.
    // Two delay stages plus the capture register give the fixed latency of 3.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            disp_dly        <= '0;
            disp_data_valid <= 1'b0;
            disp_data       <= '0;
        end else begin
            disp_dly        <= {disp_dly[0], disp_req};
            disp_data_valid <= disp_dly[1];
            if (disp_dly[1]) disp_data <= mem_rdata;
        end
    end

endmodule
